// File: rtl/calc_button_conditioner.sv
// Four-button front end: 2-flop synchroniser, per-button debounce FSM with single
// press pulse, and a registered priority encoder producing one command strobe.
module calc_button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int CNT_W           = 18
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       B1,
  input  logic       B2,
  input  logic       B3,
  input  logic       B4,
  output logic [3:0] LEVEL,
  output logic [3:0] PRESS,
  output logic [2:0] CMD,
  output logic       CMD_VALID
);

  typedef enum logic [1:0] {
    RELEASED,
    PRESS_WAIT,
    HELD,
    RELEASE_WAIT
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

  logic [3:0]       raw;
  logic [3:0]       s1;
  logic [3:0]       s2;
  state_t           state      [4];
  state_t           state_next [4];
  logic [CNT_W-1:0] cnt        [4];
  logic [CNT_W-1:0] cnt_next   [4];
  logic [3:0]       press_next;
  logic [3:0]       level_next;

  assign raw = {B4, B3, B2, B1};

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      s1 <= '1;
      s2 <= '1;
    end else begin
      s1 <= raw;
      s2 <= s1;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int unsigned i = 0; i < 4; i++) begin
        state[i] <= RELEASED;
        cnt[i]   <= '0;
      end
      PRESS <= '0;
      LEVEL <= '0;
    end else begin
      for (int unsigned i = 0; i < 4; i++) begin
        state[i] <= state_next[i];
        cnt[i]   <= cnt_next[i];
      end
      PRESS <= press_next;
      LEVEL <= level_next;
    end
  end

  // LEVEL is registered from the next state so it rises on the same edge as PRESS.
  always_comb begin
    press_next = '0;
    level_next = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      state_next[i] = state[i];
      cnt_next[i]   = cnt[i];
      case (state[i])
        RELEASED: begin
          if (!s2[i]) begin
            state_next[i] = PRESS_WAIT;
            cnt_next[i]   = CNT_W'(1);
          end
        end
        PRESS_WAIT: begin
          if (s2[i]) begin
            state_next[i] = RELEASED;
            cnt_next[i]   = '0;
          end else if (cnt[i] == CNT_MAX) begin
            state_next[i] = HELD;
            cnt_next[i]   = '0;
            press_next[i] = 1'b1;
          end else begin
            cnt_next[i] = cnt[i] + 1'b1;
          end
        end
        HELD: begin
          if (s2[i]) begin
            state_next[i] = RELEASE_WAIT;
            cnt_next[i]   = CNT_W'(1);
          end
        end
        RELEASE_WAIT: begin
          if (!s2[i]) begin
            state_next[i] = HELD;
            cnt_next[i]   = '0;
          end else if (cnt[i] == CNT_MAX) begin
            state_next[i] = RELEASED;
            cnt_next[i]   = '0;
          end else begin
            cnt_next[i] = cnt[i] + 1'b1;
          end
        end
        default: begin
          state_next[i] = RELEASED;
          cnt_next[i]   = '0;
        end
      endcase
      level_next[i] = (state_next[i] == HELD) || (state_next[i] == RELEASE_WAIT);
    end
  end

  // B4 > B3 > B2 > B1; CMD holds its last code between strobes.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      CMD       <= '0;
      CMD_VALID <= 1'b0;
    end else if (|PRESS) begin
      CMD_VALID <= 1'b1;
      if (PRESS[3])      CMD <= 3'd4;
      else if (PRESS[2]) CMD <= 3'd3;
      else if (PRESS[1]) CMD <= 3'd2;
      else               CMD <= 3'd1;
    end else begin
      CMD_VALID <= 1'b0;
    end
  end

endmodule

// File: tb/tb_calc_button_conditioner.sv
// Directed bench for calc_button_conditioner: DEBOUNCE_CYCLES=4 main instance and
// a DEBOUNCE_CYCLES=1 instance for the minimum-debounce boundary.
module tb_calc_button_conditioner;

  logic       CLK;
  logic       RST_N;
  logic       B1, B2, B3, B4;
  logic       C1, C2, C3, C4;
  logic [3:0] LEVEL, PRESS, LEVEL1, PRESS1;
  logic [2:0] CMD, CMD1;
  logic       CMD_VALID, CMD_VALID1;

  int pass_cnt = 0;
  int total    = 0;
  int pcnt  [4];
  int pcnt1 [4];
  int vcnt, vcnt1, lvl_seen;

  calc_button_conditioner #(.DEBOUNCE_CYCLES(4), .CNT_W(3)) dut (
    .CLK(CLK), .RST_N(RST_N), .B1(B1), .B2(B2), .B3(B3), .B4(B4),
    .LEVEL(LEVEL), .PRESS(PRESS), .CMD(CMD), .CMD_VALID(CMD_VALID)
  );

  calc_button_conditioner #(.DEBOUNCE_CYCLES(1), .CNT_W(1)) dut1 (
    .CLK(CLK), .RST_N(RST_N), .B1(C1), .B2(C2), .B3(C3), .B4(C4),
    .LEVEL(LEVEL1), .PRESS(PRESS1), .CMD(CMD1), .CMD_VALID(CMD_VALID1)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  task automatic clear_counts();
    for (int b = 0; b < 4; b++) begin
      pcnt[b]  = 0;
      pcnt1[b] = 0;
    end
    vcnt = 0; vcnt1 = 0; lvl_seen = 0;
  endtask

  // Advance n edges, sampling 1 time unit after each edge and tallying activity.
  task automatic run(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge CLK);
      #1;
      for (int b = 0; b < 4; b++) begin
        if (PRESS[b])  pcnt[b]++;
        if (PRESS1[b]) pcnt1[b]++;
      end
      if (CMD_VALID)  vcnt++;
      if (CMD_VALID1) vcnt1++;
      if (|LEVEL)     lvl_seen++;
    end
  endtask

  task automatic test_reset();
    RST_N = 1'b0;
    {B1, B2, B3, B4} = '1;
    {C1, C2, C3, C4} = '1;
    #23;
    total++;
    if ({LEVEL, PRESS, CMD, CMD_VALID} !== 12'h000)
      $display("FAIL reset_outputs: got %h want 000", {LEVEL, PRESS, CMD, CMD_VALID});
    else pass_cnt++;
    RST_N = 1'b1;
    run(3);
  endtask

  task automatic test_clean_press();
    B1 = 1'b0;
    run(6);
    total++;
    if (PRESS !== 4'b0000 || LEVEL !== 4'b0000)
      $display("FAIL t1_early: press %b level %b want 0000 0000", PRESS, LEVEL);
    else pass_cnt++;
    run(1);
    total++;
    if (PRESS !== 4'b0001 || LEVEL !== 4'b0001 || CMD_VALID !== 1'b0)
      $display("FAIL t1_press: press %b level %b valid %b want 0001 0001 0", PRESS, LEVEL, CMD_VALID);
    else pass_cnt++;
    run(1);
    total++;
    if (PRESS !== 4'b0000 || CMD_VALID !== 1'b1 || CMD !== 3'd1)
      $display("FAIL t1_cmd: press %b valid %b cmd %0d want 0000 1 1", PRESS, CMD_VALID, CMD);
    else pass_cnt++;
    run(12);
    B1 = 1'b1;
    run(6);
    total++;
    if (LEVEL !== 4'b0001)
      $display("FAIL t1_release_early: level %b want 0001", LEVEL);
    else pass_cnt++;
    run(1);
    total++;
    if (LEVEL !== 4'b0000 || CMD_VALID !== 1'b0 || CMD !== 3'd1)
      $display("FAIL t1_release: level %b valid %b cmd %0d want 0000 0 1", LEVEL, CMD_VALID, CMD);
    else pass_cnt++;
    run(5);
  endtask

  task automatic test_glitch();
    for (int len = 3; len <= 4; len++) begin
      clear_counts();
      B2 = 1'b0;
      run(len);
      B2 = 1'b1;
      run(15);
      total++;
      if (pcnt[1] != 0 || vcnt != 0 || lvl_seen != 0)
        $display("FAIL t2_glitch_%0d: presses %0d strobes %0d level_cycles %0d want 0 0 0",
                 len, pcnt[1], vcnt, lvl_seen);
      else pass_cnt++;
    end
    clear_counts();
    B2 = 1'b0;
    run(5);
    B2 = 1'b1;
    run(20);
    total++;
    if (pcnt[1] != 1 || vcnt != 1 || CMD !== 3'd2 || LEVEL !== 4'b0000)
      $display("FAIL t2_stable5: presses %0d strobes %0d cmd %0d level %b want 1 1 2 0000",
               pcnt[1], vcnt, CMD, LEVEL);
    else pass_cnt++;
  endtask

  task automatic test_hold_bounce();
    int drops;
    bit accepted;
    drops = 0;
    accepted = 1'b0;
    clear_counts();
    for (int c = 0; c < 1000; c++) begin
      B3 = (c >= 100 && (c % 50) < 2) ? 1'b1 : 1'b0;
      run(1);
      if (pcnt[2] > 0) accepted = 1'b1;
      if (accepted && !LEVEL[2]) drops++;
    end
    total++;
    if (pcnt[2] != 1 || vcnt != 1 || CMD !== 3'd3)
      $display("FAIL t3_single: presses %0d strobes %0d cmd %0d want 1 1 3", pcnt[2], vcnt, CMD);
    else pass_cnt++;
    total++;
    if (drops != 0)
      $display("FAIL t3_level: level low cycles %0d want 0", drops);
    else pass_cnt++;
    B3 = 1'b1;
    run(20);
    total++;
    if (LEVEL !== 4'b0000)
      $display("FAIL t3_release: level %b want 0000", LEVEL);
    else pass_cnt++;
  endtask

  task automatic test_priority();
    clear_counts();
    B1 = 1'b0;
    B4 = 1'b0;
    run(7);
    total++;
    if (PRESS !== 4'b1001 || LEVEL !== 4'b1001)
      $display("FAIL t4_press: press %b level %b want 1001 1001", PRESS, LEVEL);
    else pass_cnt++;
    run(1);
    total++;
    if (PRESS !== 4'b0000 || CMD_VALID !== 1'b1 || CMD !== 3'd4)
      $display("FAIL t4_cmd: press %b valid %b cmd %0d want 0000 1 4", PRESS, CMD_VALID, CMD);
    else pass_cnt++;
    run(10);
    total++;
    if (vcnt != 1 || CMD !== 3'd4)
      $display("FAIL t4_hold: strobes %0d cmd %0d want 1 4", vcnt, CMD);
    else pass_cnt++;
    B1 = 1'b1;
    B4 = 1'b1;
    run(20);
  endtask

  task automatic test_back_to_back();
    B1 = 1'b0;
    run(1);
    B2 = 1'b0;
    run(7);
    total++;
    if (CMD_VALID !== 1'b1 || CMD !== 3'd1 || PRESS !== 4'b0010)
      $display("FAIL b2b_first: valid %b cmd %0d press %b want 1 1 0010", CMD_VALID, CMD, PRESS);
    else pass_cnt++;
    run(1);
    total++;
    if (CMD_VALID !== 1'b1 || CMD !== 3'd2 || LEVEL !== 4'b0011)
      $display("FAIL b2b_second: valid %b cmd %0d level %b want 1 2 0011", CMD_VALID, CMD, LEVEL);
    else pass_cnt++;
    B1 = 1'b1;
    B2 = 1'b1;
    run(20);
  endtask

  task automatic test_reset_mid_hold();
    B4 = 1'b0;
    run(10);
    total++;
    if (LEVEL !== 4'b1000 || CMD !== 3'd4)
      $display("FAIL t5_setup: level %b cmd %0d want 1000 4", LEVEL, CMD);
    else pass_cnt++;
    B4 = 1'b1;
    run(20);
    B2 = 1'b0;
    run(10);
    RST_N = 1'b0;
    #2;
    total++;
    if ({LEVEL, PRESS, CMD, CMD_VALID} !== 12'h000)
      $display("FAIL t5_async_reset: got %h want 000", {LEVEL, PRESS, CMD, CMD_VALID});
    else pass_cnt++;
    run(2);
    RST_N = 1'b1;
    clear_counts();
    run(6);
    total++;
    if (PRESS !== 4'b0000 || LEVEL !== 4'b0000)
      $display("FAIL t5_redebounce: press %b level %b want 0000 0000", PRESS, LEVEL);
    else pass_cnt++;
    run(1);
    total++;
    if (PRESS !== 4'b0010 || LEVEL !== 4'b0010)
      $display("FAIL t5_press: press %b level %b want 0010 0010", PRESS, LEVEL);
    else pass_cnt++;
    run(10);
    total++;
    if (pcnt[1] != 1 || vcnt != 1 || CMD !== 3'd2)
      $display("FAIL t5_cmd: presses %0d strobes %0d cmd %0d want 1 1 2", pcnt[1], vcnt, CMD);
    else pass_cnt++;
    B2 = 1'b1;
    run(20);
  endtask

  task automatic test_min_debounce();
    clear_counts();
    C4 = 1'b0;
    run(1);
    C4 = 1'b1;
    run(8);
    total++;
    if (pcnt1[3] != 0 || vcnt1 != 0 || LEVEL1 !== 4'b0000)
      $display("FAIL t6_single_edge: presses %0d strobes %0d level %b want 0 0 0000",
               pcnt1[3], vcnt1, LEVEL1);
    else pass_cnt++;
    C4 = 1'b0;
    run(3);
    total++;
    if (PRESS1 !== 4'b0000)
      $display("FAIL t6_early: press %b want 0000", PRESS1);
    else pass_cnt++;
    run(1);
    total++;
    if (PRESS1 !== 4'b1000 || LEVEL1 !== 4'b1000)
      $display("FAIL t6_press: press %b level %b want 1000 1000", PRESS1, LEVEL1);
    else pass_cnt++;
    run(1);
    total++;
    if (CMD_VALID1 !== 1'b1 || CMD1 !== 3'd4)
      $display("FAIL t6_cmd: valid %b cmd %0d want 1 4", CMD_VALID1, CMD1);
    else pass_cnt++;
    C4 = 1'b1;
    run(6);
    total++;
    if (LEVEL1 !== 4'b0000 || pcnt1[3] != 1)
      $display("FAIL t6_release: level %b presses %0d want 0000 1", LEVEL1, pcnt1[3]);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_glitch();
    test_hold_bounce();
    test_priority();
    test_back_to_back();
    test_reset_mid_hold();
    test_min_debounce();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
